// File: rtl/serial_adder_ctrl_if.sv
// Request/response and full-adder hookup for serial_adder_ctrl.
// The master modport is the requester plus the external 1-bit full adder.
interface serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             carry_in;
  logic             abort_in;
  logic             ready_out;
  logic             busy_out;
  logic             done_out;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;
  logic             fa_a_out;
  logic             fa_b_out;
  logic             fa_cin_out;
  logic             fa_sum_in;
  logic             fa_cout_in;

  modport master (
    output start_in, a_in, b_in, carry_in, abort_in, fa_sum_in, fa_cout_in,
    input  ready_out, busy_out, done_out, sum_out, carry_out,
    input  fa_a_out, fa_b_out, fa_cin_out
  );

  modport slave (
    input  start_in, a_in, b_in, carry_in, abort_in, fa_sum_in, fa_cout_in,
    output ready_out, busy_out, done_out, sum_out, carry_out,
    output fa_a_out, fa_b_out, fa_cin_out
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: drives a shared external 1-bit full adder LSB first,
// collecting the sum over WIDTH cycles and pulsing done for one cycle.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic                clk_in,
  input logic                rst_n_in,
  serial_adder_ctrl_if.slave bus_io
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, acc_q, res_sum_q;
  logic             c_q, res_c_q;
  logic             ready_q, busy_q, done_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] acc_d;

  assign acc_d = {bus_io.fa_sum_in, acc_q[WIDTH-1:1]};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= StIdle;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      acc_q     <= '0;
      c_q       <= 1'b0;
      cnt_q     <= '0;
      res_sum_q <= '0;
      res_c_q   <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus_io.start_in) begin
            a_sh_q  <= bus_io.a_in;
            b_sh_q  <= bus_io.b_in;
            c_q     <= bus_io.carry_in;
            cnt_q   <= '0;
            acc_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          // Abort takes priority, even on the final bit, so results stay untouched.
          if (bus_io.abort_in) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            acc_q  <= acc_d;
            c_q    <= bus_io.fa_cout_in;
            a_sh_q <= {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_q <= {1'b0, b_sh_q[WIDTH-1:1]};
            cnt_q  <= cnt_q + CntW'(1);
            if (cnt_q == CntW'(WIDTH - 1)) begin
              res_sum_q <= acc_d;
              res_c_q   <= bus_io.fa_cout_in;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= StDone;
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus_io.ready_out  = ready_q;
  assign bus_io.busy_out   = busy_q;
  assign bus_io.done_out   = done_q;
  assign bus_io.sum_out    = res_sum_q;
  assign bus_io.carry_out  = res_c_q;
  // Full-adder drive is forced low outside RUN.
  assign bus_io.fa_a_out   = busy_q & a_sh_q[0];
  assign bus_io.fa_b_out   = busy_q & b_sh_q[0];
  assign bus_io.fa_cin_out = busy_q & c_q;
endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

- Bit-serial adder controller that sequences a single external 1-bit full adder to add two WIDTH-bit operands plus carry-in over WIDTH clock cycles.
- Accepts operands with a start/ready handshake and feeds the full adder one bit per cycle, LSB first.
- Registers the carry between bits, assembles the WIDTH-bit sum and final carry-out, and reports completion with a one-cycle done pulse.
- Sits between a requesting unit and the shared 1-bit full-adder datapath, trading area for latency.

## Interface

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range ≥ 2.

Ports:
- clk_in, input, 1: single clock; all state changes on its rising edge.
- rst_n_in, input, 1: asynchronous active-low reset.
- start_in, input, 1: request; a transfer happens on an edge where start_in=1 and ready_out=1.
- a_in, input, WIDTH: operand A; sampled at acceptance.
- b_in, input, WIDTH: operand B; sampled at acceptance.
- carry_in, input, 1: initial carry; sampled at acceptance.
- abort_in, input, 1: synchronous abort of a running operation.
- ready_out, output, 1: high only in IDLE.
- busy_out, output, 1: high only in RUN.
- done_out, output, 1: one-cycle completion pulse.
- sum_out, output, WIDTH: last completed sum; held between operations.
- carry_out, output, 1: last completed carry-out; held between operations.
- fa_a_out, output, 1: A bit to the full adder.
- fa_b_out, output, 1: B bit to the full adder.
- fa_cin_out, output, 1: carry bit to the full adder.
- fa_sum_in, input, 1: sum bit from the full adder, combinational in the same cycle.
- fa_cout_in, input, 1: carry bit from the full adder, combinational in the same cycle.

## Operation

Internal state:
- a_sh, b_sh: WIDTH-bit operand shift registers.
- c_reg: running carry.
- acc: WIDTH-bit working sum.
- bit_cnt: $clog2(WIDTH+1) bits.
- res_sum, res_c: result registers driving sum_out and carry_out.

FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready_out=1.
  - On start_in=1: a_sh<=a_in, b_sh<=b_in, c_reg<=carry_in, bit_cnt<=0, acc<=0, go to RUN.
- RUN:
  - Full-adder drive: fa_a_out=a_sh[0], fa_b_out=b_sh[0], fa_cin_out=c_reg.
  - Each edge:
    - acc <= {fa_sum_in, acc[WIDTH-1:1]};
    - c_reg <= fa_cout_in;
    - a_sh and b_sh shift right one place with 0 fill;
    - bit_cnt increments.
  - On the edge where bit_cnt==WIDTH-1:
    - res_sum <= {fa_sum_in, acc[WIDTH-1:1]};
    - res_c <= fa_cout_in;
    - go to DONE.
- DONE:
  - done_out=1 for exactly one cycle.
  - Next edge: go to IDLE unconditionally.

Arithmetic:
- {carry_out, sum_out} = a + b + carry_in, computed modulo 2^(WIDTH+1). No overflow flag.

Boundary rules:
- start_in outside IDLE is ignored; no queueing.
- fa_a_out, fa_b_out and fa_cin_out are 0 in IDLE and DONE.
- abort_in=1 in RUN:
  - next edge goes to IDLE;
  - res_sum and res_c are unchanged;
  - no done_out pulse.
- abort_in has no effect in IDLE or DONE.
- start_in and abort_in both high in IDLE: start is accepted.
- Operands are captured at acceptance. Changes on a_in, b_in or carry_in during RUN do not affect the result.

## Timing

- Reset (rst_n_in=0, asynchronous):
  - state=IDLE; all registers clear to 0.
  - ready_out=1; busy_out=0; done_out=0.
  - sum_out=0; carry_out=0; all fa_*_out=0.
  - Reset asserted mid-RUN discards the operation immediately; no done_out pulse.
- Latency, with acceptance on edge E0:
  - RUN occupies the cycles from E0 to E_WIDTH.
  - sum_out and carry_out update at E_WIDTH.
  - done_out is high from E_WIDTH to E_WIDTH+1.
  - ready_out returns high after E_WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles. The earliest next acceptance is at E_WIDTH+2.
- sum_out and carry_out are valid in the same cycle that done_out is high.

## Test plan

- WIDTH=8: start with a_in=0x5A, b_in=0x33, carry_in=0 -> done_out pulses at cycle 8 after acceptance; sum_out=0x8D, carry_out=0.
- Operands 0xFF + 0x01 + 0 -> sum_out=0x00, carry_out=1. Then 0xFF + 0xFF + 1 -> sum_out=0xFF, carry_out=1. Then 0x00 + 0x00 + 1 -> sum_out=0x01, carry_out=0.
- Busy rejection:
  - Hold start_in=1 continuously with new operands applied 3 cycles after acceptance.
  - Required: the first result uses only the originally captured operands.
  - Required: the second acceptance happens exactly WIDTH+2 cycles after the first.
- Abort mid-RUN:
  - Complete 0x10 + 0x20 (result 0x30).
  - Start 0xAA + 0x55, then assert abort_in at bit 4.
  - Required: IDLE on the next edge, no done_out, sum_out remains 0x30, carry_out remains 0.
- Asynchronous reset asserted mid-RUN without a clock edge:
  - Required: outputs go to reset values immediately.
  - Required: after release, 0x01 + 0x01 + 0 -> sum_out=0x02.
- Randomised sweep, 500 operations with random a_in, b_in, carry_in and start gaps:
  - Required: {carry_out, sum_out} matches a + b + carry_in for every operation.
  - Required: exactly one done_out pulse per accepted, non-aborted operation.
